// File: rtl/alu_pkg.sv
// ALU control codes, ALUOp encodings and the funct3/funct7 decoder, shared with ALU_unit.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 4;

  typedef logic [CTRL_W-1:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND     = 4'b0000;
  localparam alu_ctrl_t ALU_OR      = 4'b0001;
  localparam alu_ctrl_t ALU_ADD     = 4'b0010;
  localparam alu_ctrl_t ALU_XOR     = 4'b0011;
  localparam alu_ctrl_t ALU_SLT     = 4'b0100;
  localparam alu_ctrl_t ALU_SLL     = 4'b0101;
  localparam alu_ctrl_t ALU_SUB     = 4'b0110;
  localparam alu_ctrl_t ALU_SRL     = 4'b1001;
  localparam alu_ctrl_t ALU_SRA     = 4'b1010;
  localparam alu_ctrl_t ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  // funct7_b5 only distinguishes SUB from ADD for R-type; ADDI keeps ADD
  // whatever bit 30 holds. SLTU (funct3=011) has no ALU code.
  function automatic alu_ctrl_t alu_decode(input logic [1:0] alu_op,
                                           input logic [2:0] funct3,
                                           input logic       funct7_b5);
    alu_ctrl_t ctrl;
    ctrl = ALU_ILLEGAL;
    case (alu_op_e'(alu_op))
      ALUOP_LDST:   ctrl = ALU_ADD;
      ALUOP_BRANCH: ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ctrl = ((alu_op_e'(alu_op) == ALUOP_RTYPE) && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          3'b111:  ctrl = ALU_AND;
          default: ctrl = ALU_ILLEGAL;
        endcase
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue bus from the ALU issue stage (master) to the ALU (slave).
// Latency: wires only.
// Backpressure: slave holds out_ready low to stall; master holds payload while stalled.
interface alu_issue_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) ();
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   A;
  logic [XLEN-1:0]   B;
  logic [CTRL_W-1:0] Control_in;
  logic              illegal;

  modport master (output out_valid, A, B, Control_in, illegal, input out_ready);
  modport slave  (input out_valid, A, B, Control_in, illegal, output out_ready);
endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid register.
// Latency: 1 cycle from input handshake to out_vld when unstalled.
// Backpressure: in_rdy is a flop (= skid empty); flush drops both entries and any incoming beat.
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  // Bit 0 = output register holds a beat, bit 1 = skid register holds a beat,
  // so out_vld and in_rdy come straight off state flops.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] out_dat_q, out_dat_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         in_fire;
  logic         out_fire;

  assign out_vld = state_q[0];
  assign in_rdy  = ~state_q[1];
  assign out_dat = out_dat_q;

  // Next-state and payload steering; flush overrides any handshake.
  always_comb begin
    in_fire    = in_vld && in_rdy && !flush;
    out_fire   = out_vld && out_rdy && !flush;
    state_d    = state_q;
    out_dat_d  = out_dat_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d   = S_ONE;
            out_dat_d = in_dat;
          end
        end
        S_ONE: begin
          if (out_fire) begin
            // Consumed: reload from input or drain.
            if (in_fire) begin
              out_dat_d = in_dat;
            end else begin
              state_d = S_EMPTY;
            end
          end else if (in_fire) begin
            // Stalled: park the new beat behind the held one.
            state_d    = S_TWO;
            skid_dat_d = in_dat;
          end
        end
        S_TWO: begin
          // in_rdy is low here, so only the skid-to-output move can happen.
          if (out_fire) begin
            state_d   = S_ONE;
            out_dat_d = skid_dat_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      out_dat_q  <= '0;
      skid_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      out_dat_q  <= out_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decodes ALUOp/funct3/funct7[5] into the ALU control code, muxes operand B, and registers both toward the ALU.
// Latency: 1 cycle from input handshake to A/B/Control_in when unstalled.
// Backpressure: registered in_ready via a 2-entry skid buffer; flush empties the stage next cycle.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = alu_pkg::XLEN,
  parameter int CTRL_W = alu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_b5,
  input  logic              alu_src,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [XLEN-1:0]   imm,
  alu_issue_stage_if.master alu_bus
);

  // Payload layout: {illegal, Control_in, A, B}.
  localparam int PL_W = 2*XLEN + CTRL_W + 1;

  logic [CTRL_W-1:0] ctrl;
  logic              ill;
  logic [XLEN-1:0]   b_sel;
  logic [PL_W-1:0]   in_pl;
  logic [PL_W-1:0]   out_pl;

  // Decode and B-operand select ahead of the registers.
  always_comb begin
    ctrl  = CTRL_W'(alu_decode(alu_op, funct3, funct7_b5));
    ill   = (ctrl == CTRL_W'(ALU_ILLEGAL));
    b_sel = alu_src ? imm : rs2_val;
    in_pl = {ill, ctrl, rs1_val, b_sel};
  end

  alu_skid_buf #(
    .W(PL_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .in_dat  (in_pl),
    .out_vld (alu_bus.out_valid),
    .out_rdy (alu_bus.out_ready),
    .out_dat (out_pl)
  );

  assign {alu_bus.illegal, alu_bus.Control_in, alu_bus.A, alu_bus.B} = out_pl;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed decode vectors, stall/skid, flush, reset and streaming.
// Latency: expects 1-cycle issue latency.
// Backpressure: drives out_ready low to build stalls.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        alu_src;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;

  alu_issue_stage_if #(.XLEN(32), .CTRL_W(4)) alu_if ();

  alu_issue_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .alu_src   (alu_src),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (imm),
    .alu_bus   (alu_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       src;
    logic [3:0] ctrl;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        ill;
  } exp_t;

  vec_t vt [14];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   stall_cnt = 0;
  int   cycles = 0;

  always @(posedge clk) cycles <= cycles + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Present one beat from table row idx; push its expected result once accepted.
  task automatic send(input int idx, input logic [31:0] a, input logic [31:0] rb, input logic [31:0] im);
    int   n;
    exp_t e;
    alu_op    = vt[idx].op;
    funct3    = vt[idx].f3;
    funct7_b5 = vt[idx].f7;
    alu_src   = vt[idx].src;
    rs1_val   = a;
    rs2_val   = rb;
    imm       = im;
    in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end else begin
      stall_cnt += n;
      if (!flush) begin
        e.a    = a;
        e.b    = vt[idx].src ? im : rb;
        e.ctrl = vt[idx].ctrl;
        e.ill  = (vt[idx].ctrl == 4'b1111);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && !flush && alu_if.out_valid && alu_if.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got A=%0h Control_in=%0h, expected no beat", alu_if.A, alu_if.Control_in);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        check("mon_A", alu_if.A, e.a);
        check("mon_B", alu_if.B, e.b);
        check("mon_ctrl", {28'd0, alu_if.Control_in}, {28'd0, e.ctrl});
        check("mon_illegal", {31'd0, alu_if.illegal}, {31'd0, e.ill});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c0;
    // op, f3, f7b5, alu_src, expected Control_in
    vt[0]  = '{2'b00, 3'b010, 1'b0, 1'b1, 4'b0010};  // load/store -> ADD
    vt[1]  = '{2'b01, 3'b000, 1'b0, 1'b0, 4'b0110};  // branch -> SUB
    vt[2]  = '{2'b10, 3'b000, 1'b1, 1'b0, 4'b0110};  // R SUB
    vt[3]  = '{2'b10, 3'b000, 1'b0, 1'b0, 4'b0010};  // R ADD
    vt[4]  = '{2'b11, 3'b000, 1'b1, 1'b1, 4'b0010};  // ADDI, f7b5 ignored
    vt[5]  = '{2'b10, 3'b001, 1'b0, 1'b0, 4'b0101};  // SLL
    vt[6]  = '{2'b10, 3'b010, 1'b0, 1'b0, 4'b0100};  // SLT
    vt[7]  = '{2'b10, 3'b100, 1'b0, 1'b0, 4'b0011};  // XOR
    vt[8]  = '{2'b10, 3'b101, 1'b0, 1'b0, 4'b1001};  // SRL
    vt[9]  = '{2'b11, 3'b101, 1'b1, 1'b1, 4'b1010};  // SRAI
    vt[10] = '{2'b10, 3'b110, 1'b0, 1'b0, 4'b0001};  // OR
    vt[11] = '{2'b10, 3'b111, 1'b0, 1'b0, 4'b0000};  // AND
    vt[12] = '{2'b11, 3'b011, 1'b0, 1'b1, 4'b1111};  // SLTIU -> illegal
    vt[13] = '{2'b10, 3'b011, 1'b0, 1'b0, 4'b1111};  // SLTU -> illegal

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_if.out_ready = 1'b0;
    alu_op = '0; funct3 = '0; funct7_b5 = 1'b0; alu_src = 1'b0;
    rs1_val = '0; rs2_val = '0; imm = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, alu_if.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ctrl", {28'd0, alu_if.Control_in}, 32'd0);
    check("rst_A", alu_if.A, 32'd0);
    check("rst_B", alu_if.B, 32'd0);
    check("rst_illegal", {31'd0, alu_if.illegal}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // R-type SUB, one-cycle latency
    alu_if.out_ready = 1'b1;
    send(2, 32'd5, 32'd3, 32'd77);
    @(negedge clk);
    check("lat_out_valid", {31'd0, alu_if.out_valid}, 32'd1);
    check("lat_ctrl", {28'd0, alu_if.Control_in}, 32'h6);
    check("lat_A", alu_if.A, 32'd5);
    check("lat_B", alu_if.B, 32'd3);
    @(posedge clk); #1;

    // Whole decode table back to back (SRAI with imm=4, illegal encodings included)
    for (int i = 0; i < 14; i++) send(i, 32'h100 + i, 32'h200 + i, (i == 9) ? 32'd4 : 32'h300 + i);
    repeat (2) @(posedge clk); #1;

    // Stall: X held, Y in skid, in_ready drops, then drain in order
    alu_if.out_ready = 1'b0;
    send(3, 32'hAAAA0001, 32'h11, 32'h0);
    send(7, 32'hBBBB0002, 32'h22, 32'h0);
    repeat (2) @(negedge clk);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_out_valid", {31'd0, alu_if.out_valid}, 32'd1);
    check("stall_hold_A", alu_if.A, 32'hAAAA0001);
    check("stall_hold_ctrl", {28'd0, alu_if.Control_in}, 32'h2);
    @(posedge clk); #1;
    alu_if.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    check("drain_A_Y", alu_if.A, 32'hBBBB0002);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_empty", {31'd0, alu_if.out_valid}, 32'd0);
    check("drain_sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Flush in TWO state
    alu_if.out_ready = 1'b0;
    send(5, 32'hDEAD0001, 32'h1, 32'h0);
    send(6, 32'hDEAD0002, 32'h2, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", {31'd0, alu_if.out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    alu_if.out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Beat presented together with flush is dropped
    flush = 1'b1;
    send(10, 32'hF00D, 32'h5, 32'h0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_drop_valid", {31'd0, alu_if.out_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset in TWO state drops both entries
    alu_if.out_ready = 1'b0;
    send(8, 32'hCAFE0001, 32'h3, 32'h0);
    send(11, 32'hCAFE0002, 32'h4, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst2_out_valid", {31'd0, alu_if.out_valid}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_A", alu_if.A, 32'd0);
    @(posedge clk); #1;

    // Streaming: 100 beats, one per cycle, in order
    alu_if.out_ready = 1'b1;
    stall_cnt = 0;
    p0 = pops;
    c0 = cycles;
    for (int i = 0; i < 100; i++)
      send($urandom_range(0, 13), $urandom, $urandom, $urandom);
    check("stream_cycles", cycles - c0, 32'd100);
    check("stream_stalls", stall_cnt, 32'd0);
    repeat (2) @(negedge clk);
    check("stream_pops", pops - p0, 32'd100);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
